column_readout_arbiter: RTL and testbench

Downstream consumer of the 16-column pixel readout array in the ETROC2 global readout. On each event-start pulse it scans the 16 column hit flags in order from column 0 to column 15. It drains every hit waiting in each column through one-hot read strobes and tags each 46-bit hit word with its 4-bit column ID. Tagged words are pushed into a first-word-fall-through (FWFT) output FIFO with a valid/ready handshake. The block also registers and fans out the BCST word to all 16 columns.

---
 rtl/column_readout_arbiter_if.sv | 27 ++
 rtl/column_readout_arbiter.sv | 153 +++++++++++++++
 tb/tb_column_readout_arbiter.sv | 398 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/column_readout_arbiter_if.sv
// Output-side bus of the column readout arbiter: FWFT FIFO head word,
// valid/ready handshake and occupancy.
interface column_readout_arbiter_if #(
    parameter int FIFODEPTH = 8
);
    localparam int CW = $clog2(FIFODEPTH) + 1;

    logic [49:0]   dout;
    logic          doutValid;
    logic          doutReady;
    logic [CW-1:0] fifoCount;

    // Arbiter side drives the word, the sink drives ready.
    modport master (
        output dout,
        output doutValid,
        output fifoCount,
        input  doutReady
    );

    modport slave (
        input  dout,
        input  doutValid,
        input  fifoCount,
        output doutReady
    );
endinterface

// File: rtl/column_readout_arbiter.sv
// Column readout arbiter: scans the 16 column hit flags per event, drains each
// column through one-hot read strobes, tags words with the column ID and
// queues them in an FWFT output FIFO. Also registers and fans out BCST.
module column_readout_arbiter #(
    parameter int BCSTWIDTH = 27,
    parameter int FIFODEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [735:0]             colDataChain,
    input  logic [15:0]              colHitChain,
    output logic [15:0]              colReadChain,
    input  logic [BCSTWIDTH-1:0]     bcstIn,
    output logic [BCSTWIDTH*16-1:0]  colBCSTChain,
    input  logic                     evtStart,
    output logic                     evtDone,
    output logic                     evtOverlap,
    column_readout_arbiter_if.master fifo_if
);

    localparam int AW = $clog2(FIFODEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFODEPTH);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        SETTLE,
        DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [3:0]    r_ptr;
    logic [3:0]    w_ptr_next;

    logic [49:0]   r_mem [FIFODEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic [45:0]   w_hit_word;

    logic [BCSTWIDTH-1:0] r_bcst;

    assign w_full     = (r_count == FULL_COUNT);
    assign w_pop      = (r_count != '0) && fifo_if.doutReady;
    assign w_hit_word = colDataChain[46*r_ptr +: 46];

    // State and column pointer register.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
        end
    end

    // Next-state, strobe, FIFO push and event pulses.
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_push       = 1'b0;
        colReadChain = '0;
        evtDone      = 1'b0;
        evtOverlap   = 1'b0;
        case (r_state)
            IDLE: begin
                if (evtStart) begin
                    w_state_next = SCAN;
                    w_ptr_next   = '0;
                end
            end
            SCAN: begin
                evtOverlap = evtStart;
                if (colHitChain[r_ptr]) begin
                    // A full FIFO stalls here with ptr held and no strobe.
                    if (!w_full) begin
                        w_push       = 1'b1;
                        colReadChain = 16'd1 << r_ptr;
                        w_state_next = SETTLE;
                    end
                end else if (r_ptr == 4'd15) begin
                    w_state_next = DONE;
                end else begin
                    w_ptr_next = r_ptr + 4'd1;
                end
            end
            SETTLE: begin
                // Dead cycle lets the column refresh its registered hit flag.
                evtOverlap   = evtStart;
                w_state_next = SCAN;
            end
            DONE: begin
                evtOverlap   = evtStart;
                evtDone      = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage write.
    // NOTE: storage is not reset; the count gates dout, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_ptr, w_hit_word};
        end
    end

    assign fifo_if.doutValid = (r_count != '0);
    assign fifo_if.dout      = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    assign fifo_if.fifoCount = r_count;

    // BCST register, replicated into every column slice.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_bcst <= '0;
        end else begin
            r_bcst <= bcstIn;
        end
    end

    assign colBCSTChain = {16{r_bcst}};

endmodule

// File: tb/tb_column_readout_arbiter.sv
// Directed testbench for column_readout_arbiter with a behavioural model of
// the 16 pixel columns (per-column word lists, popped by the read strobes).
`timescale 1ns/1ps
module tb_column_readout_arbiter;

    localparam int BCSTWIDTH = 27;
    localparam int FIFODEPTH = 8;

    logic                    clk;
    logic                    rstn;
    logic [735:0]            colDataChain;
    logic [15:0]             colHitChain;
    logic [15:0]             colReadChain;
    logic [BCSTWIDTH-1:0]    bcstIn;
    logic [BCSTWIDTH*16-1:0] colBCSTChain;
    logic                    evtStart;
    logic                    evtDone;
    logic                    evtOverlap;

    column_readout_arbiter_if #(.FIFODEPTH(FIFODEPTH)) fifo_bus ();

    column_readout_arbiter #(
        .BCSTWIDTH(BCSTWIDTH),
        .FIFODEPTH(FIFODEPTH)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .colDataChain (colDataChain),
        .colHitChain  (colHitChain),
        .colReadChain (colReadChain),
        .bcstIn       (bcstIn),
        .colBCSTChain (colBCSTChain),
        .evtStart     (evtStart),
        .evtDone      (evtDone),
        .evtOverlap   (evtOverlap),
        .fifo_if      (fifo_bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Column model: words per column, read index advanced by strobes.
    logic [45:0] col_words [16][16];
    int          col_total [16];
    int          col_rd    [16];
    logic        col_clear;

    always @(posedge clk) begin
        for (int i = 0; i < 16; i++) begin
            if (col_clear) begin
                col_rd[i] <= 0;
            end else if (colReadChain[i] && col_rd[i] < col_total[i]) begin
                col_rd[i] <= col_rd[i] + 1;
            end
        end
    end

    always_comb begin
        colHitChain  = '0;
        colDataChain = '0;
        for (int i = 0; i < 16; i++) begin
            if (col_rd[i] < col_total[i]) begin
                colHitChain[i]          = 1'b1;
                colDataChain[46*i +: 46] = col_words[i][col_rd[i]];
            end
        end
    end

    int checks;
    int errors;

    // Activity log filled by run_cycles.
    int          cyc;
    int          strobe_cyc [$];
    logic [15:0] strobe_val [$];
    int          done_cyc [$];
    int          ov_cyc [$];
    logic [49:0] pops [$];
    int          valid_cycles;
    int          viol;
    logic [15:0] prev_strobe;

    task automatic clear_log();
        strobe_cyc.delete();
        strobe_val.delete();
        done_cyc.delete();
        ov_cyc.delete();
        pops.delete();
        valid_cycles = 0;
        viol         = 0;
        prev_strobe  = '0;
    endtask

    task automatic clear_cols();
        for (int i = 0; i < 16; i++) col_total[i] = 0;
        col_clear = 1'b1;
        @(posedge clk);
        #1 col_clear = 1'b0;
    endtask

    // Pulses evtStart so it is sampled at edge 0; returns at the start of cycle 1.
    task automatic start_event();
        cyc = 0;
        @(posedge clk);
        #1 evtStart = 1'b1;
        @(posedge clk);
        #1 evtStart = 1'b0;
    endtask

    // Samples n cycles mid-period and records observed activity.
    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            cyc++;
            @(negedge clk);
            if (colReadChain != '0) begin
                strobe_cyc.push_back(cyc);
                strobe_val.push_back(colReadChain);
                if (prev_strobe != '0) viol++;
                if ($countones(colReadChain) > 1) viol++;
            end
            prev_strobe = colReadChain;
            if (evtDone) done_cyc.push_back(cyc);
            if (evtOverlap) ov_cyc.push_back(cyc);
            if (fifo_bus.doutValid) valid_cycles++;
            if (fifo_bus.doutValid && fifo_bus.doutReady) pops.push_back(fifo_bus.dout);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bcstIn = 27'h7FFFFFF;
        evtStart = 1'b0;
        fifo_bus.doutReady = 1'b0;
        col_clear = 1'b0;
        for (int i = 0; i < 16; i++) col_total[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (colReadChain !== 16'h0 || evtDone !== 1'b0 || evtOverlap !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl strobe=%h done=%b overlap=%b required 0000/0/0", colReadChain, evtDone, evtOverlap);
        end
        checks++;
        if (fifo_bus.doutValid !== 1'b0 || fifo_bus.fifoCount !== 4'd0 || fifo_bus.dout !== 50'd0) begin
            errors++;
            $display("FAIL reset_fifo valid=%b count=%0d dout=%h required 0/0/0", fifo_bus.doutValid, fifo_bus.fifoCount, fifo_bus.dout);
        end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (colBCSTChain[k*BCSTWIDTH +: BCSTWIDTH] !== 27'h0) begin
                errors++;
                $display("FAIL reset_bcst slice %0d got %h required 0", k, colBCSTChain[k*BCSTWIDTH +: BCSTWIDTH]);
            end
        end
        rstn = 1'b1;
        clear_cols();
    endtask

    task automatic test_empty_event();
        clear_cols();
        fifo_bus.doutReady = 1'b1;
        clear_log();
        start_event();
        run_cycles(25);
        checks++;
        if (strobe_cyc.size() != 0) begin
            errors++;
            $display("FAIL empty_strobes got %0d required 0", strobe_cyc.size());
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != 17) begin
            errors++;
            $display("FAIL empty_done count=%0d first=%0d required 1 at 17", done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
        end
        checks++;
        if (valid_cycles != 0) begin
            errors++;
            $display("FAIL empty_valid got %0d valid cycles required 0", valid_cycles);
        end
    endtask

    task automatic test_sparse_hits();
        logic [49:0] exp_pop [3];
        int          exp_cyc [3];
        logic [15:0] exp_val [3];
        clear_cols();
        col_words[3][0]  = 46'h1234;
        col_words[15][0] = 46'hA;
        col_words[15][1] = 46'hB;
        col_total[3]  = 1;
        col_total[15] = 2;
        exp_pop[0] = {4'd3,  46'h1234};
        exp_pop[1] = {4'd15, 46'hA};
        exp_pop[2] = {4'd15, 46'hB};
        exp_cyc[0] = 4;  exp_cyc[1] = 18; exp_cyc[2] = 20;
        exp_val[0] = 16'h0008; exp_val[1] = 16'h8000; exp_val[2] = 16'h8000;
        fifo_bus.doutReady = 1'b1;
        clear_log();
        start_event();
        run_cycles(30);
        checks++;
        if (strobe_cyc.size() != 3) begin
            errors++;
            $display("FAIL sparse_strobe_count got %0d required 3", strobe_cyc.size());
        end
        for (int i = 0; i < 3 && i < strobe_cyc.size(); i++) begin
            checks++;
            if (strobe_cyc[i] != exp_cyc[i] || strobe_val[i] !== exp_val[i]) begin
                errors++;
                $display("FAIL sparse_strobe%0d got %h@%0d required %h@%0d", i, strobe_val[i], strobe_cyc[i], exp_val[i], exp_cyc[i]);
            end
        end
        checks++;
        if (pops.size() != 3) begin
            errors++;
            $display("FAIL sparse_pop_count got %0d required 3", pops.size());
        end
        for (int i = 0; i < 3 && i < pops.size(); i++) begin
            checks++;
            if (pops[i] !== exp_pop[i]) begin
                errors++;
                $display("FAIL sparse_dout%0d got %h required %h", i, pops[i], exp_pop[i]);
            end
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != 23) begin
            errors++;
            $display("FAIL sparse_done count=%0d first=%0d required 1 at 23", done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
        end
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL sparse_strobe_rules got %0d violations required 0", viol);
        end
    endtask

    task automatic test_backpressure();
        logic [49:0] exp_word;
        clear_cols();
        for (int i = 0; i < 10; i++) col_words[0][i] = 46'h100 + 46'(i);
        col_total[0] = 10;
        fifo_bus.doutReady = 1'b0;
        clear_log();
        start_event();
        run_cycles(30);
        checks++;
        if (strobe_cyc.size() != 8) begin
            errors++;
            $display("FAIL bp_strobe_count got %0d required 8", strobe_cyc.size());
        end else begin
            checks++;
            if (strobe_cyc[7] != 15) begin
                errors++;
                $display("FAIL bp_last_strobe got cycle %0d required 15", strobe_cyc[7]);
            end
        end
        checks++;
        if (fifo_bus.fifoCount !== 4'd8 || fifo_bus.dout !== {4'd0, 46'h100}) begin
            errors++;
            $display("FAIL bp_full count=%0d dout=%h required 8 and %h", fifo_bus.fifoCount, fifo_bus.dout, {4'd0, 46'h100});
        end
        checks++;
        if (done_cyc.size() != 0) begin
            errors++;
            $display("FAIL bp_stall_done got %0d pulses required 0", done_cyc.size());
        end
        // One-cycle ready: exactly one pop and one further strobe.
        clear_log();
        fifo_bus.doutReady = 1'b1;
        run_cycles(1);
        fifo_bus.doutReady = 1'b0;
        run_cycles(10);
        checks++;
        if (strobe_cyc.size() != 1 || pops.size() != 1) begin
            errors++;
            $display("FAIL bp_release strobes=%0d pops=%0d required 1 and 1", strobe_cyc.size(), pops.size());
        end
        checks++;
        if (fifo_bus.fifoCount !== 4'd8 || fifo_bus.dout !== {4'd0, 46'h101}) begin
            errors++;
            $display("FAIL bp_refill count=%0d dout=%h required 8 and %h", fifo_bus.fifoCount, fifo_bus.dout, {4'd0, 46'h101});
        end
        // Drain the rest and finish the event.
        clear_log();
        fifo_bus.doutReady = 1'b1;
        run_cycles(40);
        checks++;
        if (pops.size() != 9) begin
            errors++;
            $display("FAIL bp_drain_count got %0d required 9", pops.size());
        end
        for (int i = 0; i < 9 && i < pops.size(); i++) begin
            exp_word = {4'd0, 46'h101 + 46'(i)};
            checks++;
            if (pops[i] !== exp_word) begin
                errors++;
                $display("FAIL bp_drain%0d got %h required %h", i, pops[i], exp_word);
            end
        end
        checks++;
        if (done_cyc.size() != 1 || viol != 0) begin
            errors++;
            $display("FAIL bp_finish done=%0d violations=%0d required 1 and 0", done_cyc.size(), viol);
        end
    endtask

    task automatic test_overlap();
        clear_cols();
        fifo_bus.doutReady = 1'b1;
        clear_log();
        start_event();
        run_cycles(4);
        evtStart = 1'b1;
        run_cycles(1);
        evtStart = 1'b0;
        run_cycles(25);
        checks++;
        if (ov_cyc.size() != 1 || ov_cyc[0] != 5) begin
            errors++;
            $display("FAIL overlap_pulse count=%0d first=%0d required 1 at 5", ov_cyc.size(), (ov_cyc.size() > 0) ? ov_cyc[0] : -1);
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != 17) begin
            errors++;
            $display("FAIL overlap_done count=%0d first=%0d required 1 at 17", done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
        end
    endtask

    task automatic test_reset_mid_scan();
        clear_cols();
        for (int i = 0; i < 3; i++) col_words[0][i] = 46'h200 + 46'(i);
        col_words[5][0] = 46'h555;
        col_total[0] = 3;
        col_total[5] = 1;
        fifo_bus.doutReady = 1'b0;
        clear_log();
        start_event();
        run_cycles(3);
        checks++;
        if (fifo_bus.fifoCount !== 4'd2) begin
            errors++;
            $display("FAIL midrst_pre count got %0d required 2", fifo_bus.fifoCount);
        end
        rstn = 1'b0;
        run_cycles(1);
        rstn = 1'b1;
        checks++;
        if (fifo_bus.fifoCount !== 4'd0 || fifo_bus.doutValid !== 1'b0 || colReadChain !== 16'h0) begin
            errors++;
            $display("FAIL midrst_post count=%0d valid=%b strobe=%h required 0/0/0000", fifo_bus.fifoCount, fifo_bus.doutValid, colReadChain);
        end
        clear_log();
        run_cycles(30);
        checks++;
        if (done_cyc.size() != 0 || strobe_cyc.size() != 0) begin
            errors++;
            $display("FAIL midrst_quiet done=%0d strobes=%0d required 0 and 0", done_cyc.size(), strobe_cyc.size());
        end
    endtask

    task automatic test_bcst();
        bcstIn = 27'h5A5A5A5;
        @(negedge clk);
        checks++;
        if (colBCSTChain[0 +: BCSTWIDTH] !== 27'h7FFFFFF) begin
            errors++;
            $display("FAIL bcst_lag got %h required 7ffffff", colBCSTChain[0 +: BCSTWIDTH]);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (colBCSTChain[k*BCSTWIDTH +: BCSTWIDTH] !== 27'h5A5A5A5) begin
                errors++;
                $display("FAIL bcst_slice %0d got %h required 5a5a5a5", k, colBCSTChain[k*BCSTWIDTH +: BCSTWIDTH]);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        clear_log();
        test_reset();
        test_empty_event();
        test_sparse_hits();
        test_backpressure();
        test_overlap();
        test_bcst();
        test_reset_mid_scan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
